// File: rtl/rv32i_control_unit.sv
// rv32i_control_unit: main opcode decoder for the RV32I core.
// Decodes instruction[6:0] into the datapath control bundle. The outputs are
// registered, so they line up with the decode/execute pipeline boundary.
module rv32i_control_unit (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] opcodes,
  output logic       regwrite_o,
  output logic       memrd_o,
  output logic       memw_o,
  output logic       memtoreg_o,
  output logic       branch_o,
  output logic       opBsel_o,
  output logic [1:0] opAsel_o,
  output logic [1:0] extendsel_o,
  output logic [1:0] nextPCsel_o,
  output logic [2:0] aluop_o,
  output logic       illegal_o
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       regwrite;
    logic       memrd;
    logic       memw;
    logic       memtoreg;
    logic       branch;
    logic       opbsel;
    logic [1:0] opasel;
    logic [1:0] extendsel;
    logic [1:0] nextpcsel;
    logic [2:0] aluop;
    logic       illegal;
  } ctrl_t;

  ctrl_t dec;
  ctrl_t ctrl_q;

  // Opcode-only decode; funct3/funct7 are resolved by the ALU control block.
  always_comb begin
    dec = '0;
    case (opcodes)
      OP_RTYPE: begin
        dec.regwrite = 1'b1;
        dec.aluop    = 3'b000;
      end
      OP_ITYPE: begin
        dec.regwrite = 1'b1;
        dec.opbsel   = 1'b1;
        dec.aluop    = 3'b001;
      end
      OP_LOAD: begin
        dec.regwrite = 1'b1;
        dec.memrd    = 1'b1;
        dec.memtoreg = 1'b1;
        dec.opbsel   = 1'b1;
        dec.aluop    = 3'b100;
      end
      OP_STORE: begin
        dec.memw      = 1'b1;
        dec.opbsel    = 1'b1;
        dec.extendsel = 2'b01;
        dec.aluop     = 3'b101;
      end
      OP_BRANCH: begin
        // Branch immediate comes from the branch-target unit, so I-format here.
        dec.branch    = 1'b1;
        dec.nextpcsel = 2'b01;
        dec.aluop     = 3'b010;
      end
      OP_JALR: begin
        dec.regwrite  = 1'b1;
        dec.opasel    = 2'b10;
        dec.nextpcsel = 2'b11;
        dec.aluop     = 3'b011;
      end
      OP_JAL: begin
        dec.regwrite  = 1'b1;
        dec.opasel    = 2'b10;
        dec.nextpcsel = 2'b10;
        dec.aluop     = 3'b011;
      end
      OP_LUI: begin
        dec.regwrite  = 1'b1;
        dec.opasel    = 2'b11;
        dec.opbsel    = 1'b1;
        dec.extendsel = 2'b10;
        dec.aluop     = 3'b110;
      end
      OP_AUIPC: begin
        dec.regwrite  = 1'b1;
        dec.opasel    = 2'b01;
        dec.opbsel    = 1'b1;
        dec.extendsel = 2'b10;
        dec.aluop     = 3'b111;
      end
      // Unknown opcode behaves as a NOP with no side effects, flagged illegal.
      default: dec.illegal = 1'b1;
    endcase
  end

  // Output register; reset wins over decode on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) ctrl_q <= '0;
    else       ctrl_q <= dec;
  end

  assign regwrite_o  = ctrl_q.regwrite;
  assign memrd_o     = ctrl_q.memrd;
  assign memw_o      = ctrl_q.memw;
  assign memtoreg_o  = ctrl_q.memtoreg;
  assign branch_o    = ctrl_q.branch;
  assign opBsel_o    = ctrl_q.opbsel;
  assign opAsel_o    = ctrl_q.opasel;
  assign extendsel_o = ctrl_q.extendsel;
  assign nextPCsel_o = ctrl_q.nextpcsel;
  assign aluop_o     = ctrl_q.aluop;
  assign illegal_o   = ctrl_q.illegal;

endmodule

// File: tb/tb_rv32i_control_unit.sv
// Directed bench for rv32i_control_unit: reset, opcode sweep, illegal opcodes,
// mid-stream reset, glitch immunity and random invariant checks.
module tb_rv32i_control_unit;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [6:0] opcodes;
  logic       regwrite_o, memrd_o, memw_o, memtoreg_o, branch_o, opBsel_o, illegal_o;
  logic [1:0] opAsel_o, extendsel_o, nextPCsel_o;
  logic [2:0] aluop_o;

  int total = 0;
  int bad   = 0;

  rv32i_control_unit dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .opcodes     (opcodes),
    .regwrite_o  (regwrite_o),
    .memrd_o     (memrd_o),
    .memw_o      (memw_o),
    .memtoreg_o  (memtoreg_o),
    .branch_o    (branch_o),
    .opBsel_o    (opBsel_o),
    .opAsel_o    (opAsel_o),
    .extendsel_o (extendsel_o),
    .nextPCsel_o (nextPCsel_o),
    .aluop_o     (aluop_o),
    .illegal_o   (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [6:0] RTYPE  = 7'b0110011;
  localparam logic [6:0] ITYPE  = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  // Observed bundle:
  // {regwrite,memrd,memw,memtoreg,branch,opBsel,opAsel,extendsel,nextPCsel,aluop,illegal}
  function automatic logic [15:0] obs();
    return {regwrite_o, memrd_o, memw_o, memtoreg_o, branch_o, opBsel_o,
            opAsel_o, extendsel_o, nextPCsel_o, aluop_o, illegal_o};
  endfunction

  // Hand-written expected table, same field order as obs().
  //                         rw  rd  mw  m2r br  opB opA    ext    npc    alu     ill
  function automatic logic [15:0] exp_of(input logic [6:0] op);
    case (op)
      RTYPE:  return {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,1'b0};
      ITYPE:  return {1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,3'b001,1'b0};
      LOAD:   return {1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,2'b00,2'b00,2'b00,3'b100,1'b0};
      STORE:  return {1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,2'b00,2'b01,2'b00,3'b101,1'b0};
      BRANCH: return {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b01,3'b010,1'b0};
      JALR:   return {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b11,3'b011,1'b0};
      JAL:    return {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,3'b011,1'b0};
      LUI:    return {1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b11,2'b10,2'b00,3'b110,1'b0};
      AUIPC:  return {1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b10,2'b00,3'b111,1'b0};
      default: return 16'h0001;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present inputs, take one rising edge, settle #1 after it.
  task automatic step(input logic rst, input logic [6:0] op);
    rst_i   = rst;
    opcodes = op;
    @(posedge clk_i);
    #1;
  endtask

  logic [6:0] sweep [9] = '{RTYPE, ITYPE, LOAD, STORE, BRANCH, JALR, JAL, LUI, AUIPC};
  logic [6:0] rop;

  initial begin
    rst_i   = 1'b1;
    opcodes = RTYPE;

    // Reset held two cycles with a legal opcode present.
    step(1'b1, RTYPE);
    step(1'b1, RTYPE);
    chk("reset_all_zero", {16'h0, obs()}, 32'h0);
    step(1'b0, RTYPE);
    chk("post_reset_rtype", {16'h0, obs()}, {16'h0, exp_of(RTYPE)});
    chk("post_reset_rtype_rw", {31'h0, regwrite_o}, 32'd1);

    // Back-to-back sweep over every legal opcode.
    for (int i = 0; i < 9; i++) begin
      step(1'b0, sweep[i]);
      chk($sformatf("sweep_%0d", i), {16'h0, obs()}, {16'h0, exp_of(sweep[i])});
    end

    // Spot checks on individual fields.
    step(1'b0, LOAD);
    chk("load_memrd",    {31'h0, memrd_o},    32'd1);
    chk("load_memtoreg", {31'h0, memtoreg_o}, 32'd1);
    chk("load_aluop",    {29'h0, aluop_o},    32'd4);
    step(1'b0, STORE);
    chk("store_memw",    {31'h0, memw_o},      32'd1);
    chk("store_ext",     {30'h0, extendsel_o}, 32'd1);
    chk("store_rw",      {31'h0, regwrite_o},  32'd0);
    step(1'b0, JALR);
    chk("jalr_npc",      {30'h0, nextPCsel_o}, 32'd3);
    chk("jalr_opa",      {30'h0, opAsel_o},    32'd2);

    // Illegal opcodes: flagged, no side effects.
    step(1'b0, 7'b1111111);
    chk("ill_ff_vec", {16'h0, obs()}, 32'h0001);
    chk("ill_ff_flag", {31'h0, illegal_o}, 32'd1);
    step(1'b0, 7'b0000000);
    chk("ill_00_vec", {16'h0, obs()}, 32'h0001);
    chk("ill_00_side", {29'h0, regwrite_o, memw_o, memrd_o}, 32'd0);
    step(1'b0, ITYPE);
    chk("ill_cleared", {31'h0, illegal_o}, 32'd0);
    chk("ill_then_itype", {16'h0, obs()}, {16'h0, exp_of(ITYPE)});

    // Mid-stream reset with a store in decode.
    step(1'b1, STORE);
    chk("midrst_memw", {31'h0, memw_o}, 32'd0);
    chk("midrst_all",  {16'h0, obs()}, 32'h0);
    step(1'b0, STORE);
    chk("midrst_after_memw", {31'h0, memw_o},      32'd1);
    chk("midrst_after_ext",  {30'h0, extendsel_o}, 32'd1);

    // Glitch immunity: opcode wiggles between edges must not reach outputs.
    step(1'b0, JAL);
    chk("glitch_jal0", {16'h0, obs()}, {16'h0, exp_of(JAL)});
    #2 opcodes = LUI;
    #1 chk("glitch_hold_mid", {16'h0, obs()}, {16'h0, exp_of(JAL)});
    #1 opcodes = JAL;
    @(posedge clk_i); #1;
    chk("glitch_jal1", {16'h0, obs()}, {16'h0, exp_of(JAL)});
    // Now the reverse: lui at the edge after a mid-cycle jal wiggle.
    opcodes = LUI;
    #2 opcodes = JAL;
    #2 opcodes = LUI;
    @(posedge clk_i); #1;
    chk("glitch_lui", {16'h0, obs()}, {16'h0, exp_of(LUI)});

    // Random opcodes: full-model match plus invariants every cycle.
    for (int i = 0; i < 200; i++) begin
      if (i % 3 == 0) rop = sweep[$urandom_range(8, 0)];
      else            rop = 7'($urandom_range(127, 0));
      step(1'b0, rop);
      chk("rnd_vec", {16'h0, obs()}, {16'h0, exp_of(rop)});
      chk("inv_mw_rd", {31'h0, memw_o & memrd_o}, 32'd0);
      chk("inv_m2r_rd", {31'h0, memtoreg_o & ~memrd_o}, 32'd0);
      chk("inv_br_npc", {31'h0, branch_o & (nextPCsel_o != 2'b01)}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
